// File: rtl/lod_pipe_stage.sv
// lod_pipe_stage: two-stage pipelined leading-one detector.
//
// Feeds the shift-left normalisation mux in the approximate multiplier.
// Stage 1 registers the operand together with a per-group "any one" flag
// and the local leading-one index of each group. Stage 2 picks the highest
// populated group and forms K = group*GROUP + local index.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of both stage valid bits
//   in_valid     input operand valid
//   in_ready     stage accepts the input operand this cycle
//   in_operand   unsigned operand
//   out_valid    output bundle valid
//   out_ready    downstream accepts the output bundle
//   out_operand  registered copy of the accepted operand
//   out_k        bit index of the most-significant one (0 when zero)
//   out_zero     operand was all zeros
//   out_rnd      operand[K-1] (0 if K==0 or zero); only with LOD_RND_BIT_EN
//
// Build option: define LOD_RND_BIT_EN to add the out_rnd port and register.

module lod_pipe_stage #(
    parameter int WIDTH      = 16,
    parameter int LOG2_WIDTH = 4,
    parameter int GROUP      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_operand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_operand,
    output logic [LOG2_WIDTH-1:0] out_k,
`ifdef LOD_RND_BIT_EN
    output logic                  out_rnd,
`endif
    output logic                  out_zero
);

    localparam int NG = WIDTH / GROUP;
    localparam int LG = (GROUP > 1) ? $clog2(GROUP) : 1;

    logic                  v1;
    logic                  v2;
    logic                  load1;
    logic                  load2;

    logic [WIDTH-1:0]      s1_operand;
    logic [NG-1:0]         s1_any;
    logic [NG-1:0][LG-1:0] s1_idx;

    logic [NG-1:0]         grp_any_d;
    logic [NG-1:0][LG-1:0] grp_idx_d;

    logic [LOG2_WIDTH-1:0] k_d;
    logic                  zero_d;

    // S2 may take S1's content whenever its own slot is free or draining;
    // S1 may refill in the same cycle it hands over.
    assign load2     = v1 && (!v2 || out_ready);
    assign in_ready  = !flush && (!v1 || !v2 || out_ready);
    assign load1     = in_valid && in_ready;
    assign out_valid = v2;

    // Per-group detection: ascending scan so the highest set bit wins.
    always_comb begin
        grp_any_d = '0;
        grp_idx_d = '0;
        for (int g = 0; g < NG; g++) begin
            for (int b = 0; b < GROUP; b++) begin
                if (in_operand[g*GROUP + b]) begin
                    grp_any_d[g] = 1'b1;
                    grp_idx_d[g] = LG'(b);
                end
            end
        end
    end

    // Group select: ascending scan so the highest populated group wins.
    always_comb begin
        k_d    = '0;
        zero_d = 1'b1;
        for (int g = 0; g < NG; g++) begin
            if (s1_any[g]) begin
                k_d    = LOG2_WIDTH'(g*GROUP + int'(s1_idx[g]));
                zero_d = 1'b0;
            end
        end
    end

`ifdef LOD_RND_BIT_EN
    logic [LOG2_WIDTH-1:0] k_m1;
    logic                  rnd_d;

    assign k_m1 = k_d - LOG2_WIDTH'(1);

    always_comb begin
        rnd_d = 1'b0;
        if (!zero_d && (k_d != '0)) begin
            rnd_d = s1_operand[k_m1];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (load1) begin
                v1 <= 1'b1;
            end else if (load2) begin
                v1 <= 1'b0;
            end
            if (load2) begin
                v2 <= 1'b1;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    // Data registers ignore flush; only the valid bits are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_operand <= '0;
            s1_any     <= '0;
            s1_idx     <= '0;
        end else if (load1) begin
            s1_operand <= in_operand;
            s1_any     <= grp_any_d;
            s1_idx     <= grp_idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_operand <= '0;
            out_k       <= '0;
            out_zero    <= 1'b1;
        end else if (load2) begin
            out_operand <= s1_operand;
            out_k       <= k_d;
            out_zero    <= zero_d;
        end
    end

`ifdef LOD_RND_BIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rnd <= 1'b0;
        end else if (load2) begin
            out_rnd <= rnd_d;
        end
    end
`endif

endmodule

// File: tb/tb_lod_pipe_stage.sv
// Testbench for lod_pipe_stage: a 16-bit instance (a) for directed
// streaming, backpressure, flush, rounding-bit and reset cases, and an
// 8-bit / GROUP=4 instance (b) for a randomised handshake sweep over all
// 256 operand values. Expected bundles are queued on acceptance and
// compared when the output transfers.

module tb_lod_pipe_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_zero_a;
    logic [15:0] in_operand_a, out_operand_a;
    logic [3:0]  out_k_a;

    logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_zero_b;
    logic [7:0]  in_operand_b, out_operand_b;
    logic [2:0]  out_k_b;

`ifdef LOD_RND_BIT_EN
    logic        out_rnd_a, out_rnd_b;
`endif

    lod_pipe_stage #(.WIDTH(16), .LOG2_WIDTH(4), .GROUP(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_operand(in_operand_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_operand(out_operand_a), .out_k(out_k_a),
`ifdef LOD_RND_BIT_EN
        .out_rnd(out_rnd_a),
`endif
        .out_zero(out_zero_a)
    );

    lod_pipe_stage #(.WIDTH(8), .LOG2_WIDTH(3), .GROUP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_operand(in_operand_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_operand(out_operand_b), .out_k(out_k_b),
`ifdef LOD_RND_BIT_EN
        .out_rnd(out_rnd_b),
`endif
        .out_zero(out_zero_b)
    );

    typedef struct packed {
        logic [15:0] op;
        logic [3:0]  k;
        logic        zero;
        logic        rnd;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;
    bit   acc_a, acc_b;

    // Reference: plain bit-serial priority encoder over the low w bits.
    function automatic exp_t ref_lod(logic [15:0] v, int w);
        exp_t e;
        e.op   = v;
        e.k    = '0;
        e.zero = 1'b1;
        e.rnd  = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                e.k    = 4'(i);
                e.zero = 1'b0;
            end
        end
        if (!e.zero && e.k != 4'd0) e.rnd = v[int'(e.k) - 1];
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then return 1 time
    // unit after the rising edge so the caller can drive the next inputs.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (out_valid_a && out_ready_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_output", 32'(out_valid_a), 32'd0);
                end else begin
                    e = q_a.pop_front();
                    chk("a_operand", 32'(out_operand_a), 32'(e.op));
                    chk("a_k", 32'(out_k_a), 32'(e.k));
                    chk("a_zero", 32'(out_zero_a), 32'(e.zero));
`ifdef LOD_RND_BIT_EN
                    chk("a_rnd", 32'(out_rnd_a), 32'(e.rnd));
`endif
                end
            end
            if (flush_a) q_a.delete();
            else if (in_valid_a && in_ready_a) begin
                q_a.push_back(ref_lod(in_operand_a, 16));
                acc_a = 1'b1;
            end

            if (out_valid_b && out_ready_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_output", 32'(out_valid_b), 32'd0);
                end else begin
                    e = q_b.pop_front();
                    chk("b_operand", 32'(out_operand_b), 32'(e.op));
                    chk("b_k", 32'(out_k_b), 32'(e.k));
                    chk("b_zero", 32'(out_zero_b), 32'(e.zero));
`ifdef LOD_RND_BIT_EN
                    chk("b_rnd", 32'(out_rnd_b), 32'(e.rnd));
`endif
                end
            end
            if (flush_b) q_b.delete();
            else if (in_valid_b && in_ready_b) begin
                q_b.push_back(ref_lod(16'(in_operand_b), 8));
                acc_b = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        int n = 0;
        while ((q_a.size() != 0 || out_valid_a) && n < 50) begin
            tick();
            n++;
        end
        chk("a_drain_left", 32'(q_a.size()), 32'd0);
    endtask

    task automatic drain_b();
        int n = 0;
        while ((q_b.size() != 0 || out_valid_b) && n < 50) begin
            tick();
            n++;
        end
        chk("b_drain_left", 32'(q_b.size()), 32'd0);
    endtask

    logic [15:0] stream [4];
    logic [15:0] bp     [4];
    logic [15:0] rnd_ops[4];
    int          idx;
    int          n;

    initial begin
        stream  = '{16'h0001, 16'h8000, 16'h0F00, 16'h0000};
        bp      = '{16'h0300, 16'h0040, 16'h1234, 16'h0005};
        rnd_ops = '{16'h0C00, 16'h0800, 16'h8001, 16'hC000};

        rst_n = 1'b0;
        flush_a = 1'b0; in_valid_a = 1'b0; in_operand_a = '0; out_ready_a = 1'b1;
        flush_b = 1'b0; in_valid_b = 1'b0; in_operand_b = '0; out_ready_b = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_zero", 32'(out_zero_a), 32'd1);
        chk("rst_out_k", 32'(out_k_a), 32'd0);
        chk("rst_out_operand", 32'(out_operand_a), 32'd0);
        chk("rst_b_out_zero", 32'(out_zero_b), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);
        tick();

        // Stream four operands at full rate.
        for (int i = 0; i < 4; i++) begin
            in_valid_a   = 1'b1;
            in_operand_a = stream[i];
            tick();
            chk("stream_latency_valid", 32'(out_valid_a), (i >= 1) ? 32'd1 : 32'd0);
        end
        in_valid_a = 1'b0;
        tick();
        chk("stream_last_valid", 32'(out_valid_a), 32'd1);
        tick();
        chk("stream_end_valid", 32'(out_valid_a), 32'd0);
        drain_a();

        // Backpressure for five cycles with input always offered.
        idx = 0;
        out_ready_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid_a   = 1'b1;
            in_operand_a = bp[idx];
            #1;
            chk("bp_in_ready", 32'(in_ready_a), (c < 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk("bp_hold_valid", 32'(out_valid_a), 32'd1);
                chk("bp_hold_operand", 32'(out_operand_a), 32'(bp[0]));
            end
            tick();
            if (acc_a) idx++;
        end
        out_ready_a = 1'b1;
        n = 0;
        while (idx < 4 && n < 20) begin
            in_valid_a   = 1'b1;
            in_operand_a = bp[idx];
            tick();
            if (acc_a) idx++;
            n++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd4);
        in_valid_a = 1'b0;
        drain_a();

        // Flush with both stages full and an input offered.
        out_ready_a  = 1'b0;
        in_valid_a   = 1'b1;
        in_operand_a = 16'h00F0;
        tick();
        in_operand_a = 16'h0700;
        tick();
        chk("flush_pre_valid", 32'(out_valid_a), 32'd1);
        flush_a      = 1'b1;
        in_operand_a = 16'h4000;
        #1;
        chk("flush_in_ready", 32'(in_ready_a), 32'd0);
        tick();
        flush_a    = 1'b0;
        in_valid_a = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid_a), 32'd0);
        out_ready_a = 1'b1;
        repeat (3) tick();
        chk("flush_post_valid", 32'(out_valid_a), 32'd0);
        chk("flush_queue", 32'(q_a.size()), 32'd0);

        // Rounding-bit operands (K also checked in the default build).
        for (int i = 0; i < 4; i++) begin
            in_valid_a   = 1'b1;
            in_operand_a = rnd_ops[i];
            tick();
        end
        in_valid_a = 1'b0;
        drain_a();

        // Reset asserted with both stages full.
        out_ready_a  = 1'b0;
        in_valid_a   = 1'b1;
        in_operand_a = 16'h0020;
        tick();
        in_operand_a = 16'h2000;
        tick();
        chk("midrst_pre_valid", 32'(out_valid_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid_a), 32'd0);
        chk("midrst_out_zero", 32'(out_zero_a), 32'd1);
        chk("midrst_out_k", 32'(out_k_a), 32'd0);
        in_valid_a = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready_a), 32'd1);
        out_ready_a = 1'b1;
        repeat (3) tick();
        chk("midrst_post_valid", 32'(out_valid_a), 32'd0);

        // Random-handshake sweep over every 8-bit operand.
        idx = 0;
        n   = 0;
        while (idx < 256 && n < 4000) begin
            in_operand_b = 8'(idx);
            in_valid_b   = 1'($urandom_range(0, 1));
            out_ready_b  = 1'($urandom_range(0, 1));
            tick();
            if (acc_b) idx++;
            n++;
        end
        chk("sweep_all_accepted", 32'(idx), 32'd256);
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        drain_b();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
